// File: rtl/segment_driver.sv
// Six-digit multiplexed seven-segment driver: decodes a signed display word or message code
// into six segment patterns and scans them one digit per fnd_clk. Option: SEGMENT_ZERO_BLANK_EN.
module segment_driver (
    input  logic        fnd_clk,
    input  logic        rst,
    input  logic [31:0] fnd_serial,
    output logic [5:0]  fnd_s,
    output logic [7:0]  fnd_d
);

    localparam logic [7:0] G_BLANK = 8'h00;
    localparam logic [7:0] G_MINUS = 8'h40;
    localparam logic [7:0] G_E     = 8'h79;
    localparam logic [7:0] G_R     = 8'h50;
    localparam logic [7:0] G_LO_O  = 8'h5C;
    localparam logic [7:0] G_P     = 8'h73;
    localparam logic [7:0] G_L     = 8'h38;
    localparam logic [7:0] G_U     = 8'h3E;
    localparam logic [7:0] G_S     = 8'h6D;
    localparam logic [7:0] G_N     = 8'h54;
    localparam logic [7:0] G_I     = 8'h06;
    localparam logic [7:0] G_T     = 8'h78;
    localparam logic [7:0] G_D     = 8'h5E;
    localparam logic [7:0] G_O     = 8'h3F;
    localparam logic [7:0] G_H     = 8'h76;
    localparam logic [7:0] G_A     = 8'h77;
    localparam logic [7:0] G_Y     = 8'h6E;

    // Frames are written leftmost digit (5) first, matching the packed [5:0] order.
    localparam logic [5:0][7:0] MSG_ERROR = {G_E, G_R, G_R, G_LO_O, G_R, G_BLANK};
    localparam logic [5:0][7:0] MSG_PLUS  = {G_P, G_L, G_U, G_S, G_BLANK, G_BLANK};
    localparam logic [5:0][7:0] MSG_MINUS = {G_N, G_N, G_I, G_N, G_U, G_S};
    localparam logic [5:0][7:0] MSG_MULT  = {G_N, G_N, G_U, G_L, G_T, G_BLANK};
    localparam logic [5:0][7:0] MSG_DIV   = {G_D, G_I, G_U, G_I, G_D, G_E};
    localparam logic [5:0][7:0] MSG_MOD   = {G_N, G_N, G_O, G_D, G_BLANK, G_BLANK};
    localparam logic [5:0][7:0] MSG_HAPPY = {G_H, G_A, G_P, G_P, G_Y, G_BLANK};

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 8'h3F;
            4'd1:    digit_glyph = 8'h06;
            4'd2:    digit_glyph = 8'h5B;
            4'd3:    digit_glyph = 8'h4F;
            4'd4:    digit_glyph = 8'h66;
            4'd5:    digit_glyph = 8'h6D;
            4'd6:    digit_glyph = 8'h7D;
            4'd7:    digit_glyph = 8'h07;
            4'd8:    digit_glyph = 8'h7F;
            4'd9:    digit_glyph = 8'h6F;
            default: digit_glyph = G_BLANK;
        endcase
    endfunction

    // Shift-add-3 over all 20 magnitude bits; any digit >= 5 is corrected before each shift.
    function automatic logic [23:0] bin_to_bcd(input logic [19:0] bin);
        logic [23:0] bcd;
        bcd = '0;
        for (int i = 19; i >= 0; i--) begin
            for (int d = 0; d < 6; d++) begin
                if (bcd[4*d +: 4] >= 4'd5)
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[22:0], bin[i]};
        end
        return bcd;
    endfunction

    logic signed [31:0] sval;
    logic               neg;
    logic               in_range;
    logic [19:0]        mag;
    logic [23:0]        bcd;
    logic               msg_hit;
    logic [5:0][7:0]    msg_pat;
    logic [5:0][7:0]    pat_next;
    logic [5:0][7:0]    pat_buf;
    logic [2:0]         scan_cnt;

    assign sval     = signed'(fnd_serial);
    assign neg      = sval[31];
    assign in_range = (sval >= -32'sd99999) && (sval <= 32'sd999999);
    assign mag      = neg ? 20'(-sval) : 20'(sval);
    assign bcd      = bin_to_bcd(mag);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        msg_hit = 1'b0;
        msg_pat = '0;
        if (fnd_serial[31:24] == 8'h00 && fnd_serial[15:0] == 16'h0000) begin
            msg_hit = 1'b1;
            case (fnd_serial[23:16])
                8'hCC:   msg_pat = '0;
                8'hEE:   msg_pat = MSG_ERROR;
                8'h10:   msg_pat = MSG_PLUS;
                8'h20:   msg_pat = MSG_MINUS;
                8'h30:   msg_pat = MSG_MULT;
                8'h40:   msg_pat = MSG_DIV;
                8'h50:   msg_pat = MSG_MOD;
                8'hA0:   msg_pat = MSG_HAPPY;
                default: msg_hit = 1'b0;
            endcase
        end
    end

`ifdef SEGMENT_ZERO_BLANK_EN
    logic [2:0] msd;

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                msd = 3'(i);
        end
    end

    always_comb begin
        pat_next = '0;
        if (msg_hit) begin
            pat_next = msg_pat;
        end else if (!in_range) begin
            pat_next = MSG_ERROR;
        end else begin
            // Digits above the most significant one stay blank; the minus floats just left of it.
            for (int i = 0; i < 6; i++) begin
                if (3'(i) <= msd)
                    pat_next[i] = digit_glyph(bcd[4*i +: 4]);
                else if (neg && 3'(i) == msd + 3'd1)
                    pat_next[i] = G_MINUS;
            end
        end
    end
`else
    always_comb begin
        pat_next = '0;
        if (msg_hit) begin
            pat_next = msg_pat;
        end else if (!in_range) begin
            pat_next = MSG_ERROR;
        end else begin
            for (int i = 0; i < 5; i++)
                pat_next[i] = digit_glyph(bcd[4*i +: 4]);
            pat_next[5] = neg ? G_MINUS : digit_glyph(bcd[23:20]);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fnd_clk) begin
        if (!rst) begin
            scan_cnt <= 3'd0;
            // NOTE: the pattern buffer is reset so the first frame after reset is dark, not stale.
            pat_buf  <= '0;
            fnd_s    <= 6'b111111;
            fnd_d    <= 8'h00;
        end else begin
            pat_buf  <= pat_next;
            fnd_s    <= ~(6'b000001 << scan_cnt);
            fnd_d    <= pat_buf[scan_cnt];
            scan_cnt <= (scan_cnt == 3'd5) ? 3'd0 : scan_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_segment_driver.sv
// Self-checking bench for segment_driver: a decimal reference model feeds a scoreboard of
// expected (fnd_s, fnd_d) per edge, plus literal per-digit frame checks.
module tb_segment_driver;

    typedef logic [5:0][7:0] frame_t;
    typedef struct {
        logic [5:0] s;
        logic [7:0] d;
    } exp_t;

    logic        fnd_clk;
    logic        rst;
    logic [31:0] fnd_serial;
    logic [5:0]  fnd_s;
    logic [7:0]  fnd_d;

    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   exp_q[$];
    frame_t m_buf;
    int     m_cnt;

    segment_driver dut (
        .fnd_clk    (fnd_clk),
        .rst        (rst),
        .fnd_serial (fnd_serial),
        .fnd_s      (fnd_s),
        .fnd_d      (fnd_d)
    );

    initial begin
        fnd_clk = 1'b0;
        forever #5 fnd_clk = ~fnd_clk;
    end

    localparam frame_t F_ERROR = {8'h79, 8'h50, 8'h50, 8'h5C, 8'h50, 8'h00};

    function automatic logic [7:0] dig(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        return tbl[d];
    endfunction

    // Reference decode using plain decimal arithmetic.
    function automatic frame_t model(input logic [31:0] v);
        frame_t p;
        int     sv;
        int     mag;
        int     nd;
        logic   ng;
        p = '0;
        case (v)
            32'h00CC0000: return '0;
            32'h00EE0000: return F_ERROR;
            32'h00100000: return {8'h73, 8'h38, 8'h3E, 8'h6D, 8'h00, 8'h00};
            32'h00200000: return {8'h54, 8'h54, 8'h06, 8'h54, 8'h3E, 8'h6D};
            32'h00300000: return {8'h54, 8'h54, 8'h3E, 8'h38, 8'h78, 8'h00};
            32'h00400000: return {8'h5E, 8'h06, 8'h3E, 8'h06, 8'h5E, 8'h79};
            32'h00500000: return {8'h54, 8'h54, 8'h3F, 8'h5E, 8'h00, 8'h00};
            32'h00A00000: return {8'h76, 8'h77, 8'h73, 8'h73, 8'h6E, 8'h00};
            default: ;
        endcase
        sv = v;
        if (sv < -99999 || sv > 999999) return F_ERROR;
        ng  = (sv < 0);
        mag = ng ? -sv : sv;
`ifdef SEGMENT_ZERO_BLANK_EN
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || mag > 0) begin
                p[i] = dig(mag % 10);
                nd   = i + 1;
            end
            mag = mag / 10;
        end
        if (ng) p[nd] = 8'h40;
`else
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            p[i] = dig(mag % 10);
            mag  = mag / 10;
        end
        p[5] = ng ? 8'h40 : dig(mag % 10);
`endif
        return p;
    endfunction

    // One edge: predict outputs at stimulus time, then pop and compare after the edge.
    task automatic tick(input string tag);
        exp_t e;
        if (!rst) begin
            e.s   = 6'b111111;
            e.d   = 8'h00;
            m_cnt = 0;
            m_buf = '0;
        end else begin
            e.s   = ~(6'b000001 << m_cnt);
            e.d   = m_buf[m_cnt];
            m_buf = model(fnd_serial);
            m_cnt = (m_cnt == 5) ? 0 : m_cnt + 1;
        end
        exp_q.push_back(e);
        @(posedge fnd_clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        assert (fnd_s === e.s) else begin
            n_errors++;
            $error("FAIL %s fnd_s: got %b expected %b", tag, fnd_s, e.s);
        end
        n_checks++;
        assert (fnd_d === e.d) else begin
            n_errors++;
            $error("FAIL %s fnd_d: got %h expected %h", tag, fnd_d, e.d);
        end
    endtask

    // Drive a value, let it load, then capture one full scan and compare every digit to a literal.
    task automatic show_frame(input string tag, input logic [31:0] v, input frame_t want);
        frame_t got;
        got = '1;
        fnd_serial = v;
        tick(tag);
        for (int k = 0; k < 6; k++) begin
            tick(tag);
            for (int j = 0; j < 6; j++)
                if (fnd_s == ~(6'b000001 << j)) got[j] = fnd_d;
        end
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            assert (got[j] === want[j]) else begin
                n_errors++;
                $error("FAIL %s digit%0d: got %h expected %h", tag, j, got[j], want[j]);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        fnd_serial = 32'd0;
        m_buf      = '0;
        m_cnt      = 0;
        #2;
        for (int i = 0; i < 3; i++) tick("reset");

        rst        = 1'b1;
        fnd_serial = 32'd123;
        for (int i = 0; i < 8; i++) tick("scan");

`ifdef SEGMENT_ZERO_BLANK_EN
        show_frame("pos123", 32'd123,  {8'h00, 8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F});
        show_frame("neg1",   -32'sd1,  {8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h06});
        show_frame("neg12",  -32'sd12, {8'h00, 8'h00, 8'h00, 8'h40, 8'h06, 8'h5B});
        show_frame("zero",   32'd0,    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F});
`else
        show_frame("pos123", 32'd123,  {8'h3F, 8'h3F, 8'h3F, 8'h06, 8'h5B, 8'h4F});
        show_frame("neg1",   -32'sd1,  {8'h40, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h06});
        show_frame("neg12",  -32'sd12, {8'h40, 8'h3F, 8'h3F, 8'h3F, 8'h06, 8'h5B});
        show_frame("zero",   32'd0,    {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F});
`endif
        show_frame("neg12345", -32'sd12345, {8'h40, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D});
        show_frame("max",      32'd999999,  {8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F});
        show_frame("min",      -32'sd99999, {8'h40, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F});
        show_frame("over",     32'd1000000, F_ERROR);
        show_frame("under",    -32'sd100000, F_ERROR);
        show_frame("msg_ee",   32'h00EE0000, F_ERROR);
        show_frame("msg_a0",   32'h00A00000, {8'h76, 8'h77, 8'h73, 8'h73, 8'h6E, 8'h00});
        show_frame("msg_cc",   32'h00CC0000, '0);
        show_frame("msg_10",   32'h00100000, {8'h73, 8'h38, 8'h3E, 8'h6D, 8'h00, 8'h00});
        show_frame("msg_20",   32'h00200000, {8'h54, 8'h54, 8'h06, 8'h54, 8'h3E, 8'h6D});
        show_frame("msg_30",   32'h00300000, {8'h54, 8'h54, 8'h3E, 8'h38, 8'h78, 8'h00});
        show_frame("msg_40",   32'h00400000, {8'h5E, 8'h06, 8'h3E, 8'h06, 8'h5E, 8'h79});
        show_frame("msg_50",   32'h00500000, {8'h54, 8'h54, 8'h3F, 8'h5E, 8'h00, 8'h00});
        show_frame("near_msg", 32'h00DD0000, F_ERROR);

        // Mid-frame value changes: digits already scanned keep the old value until their turn.
        fnd_serial = 32'd456789;
        tick("midframe");
        tick("midframe");
        fnd_serial = -32'sd7;
        for (int i = 0; i < 8; i++) tick("midframe");
        fnd_serial = 32'd50;
        for (int i = 0; i < 3; i++) tick("midframe");

        // Reset mid-frame blanks outputs on the next edge and restarts at digit 0 with a blank buffer.
        rst = 1'b0;
        tick("mid_reset");
        tick("mid_reset");
        rst = 1'b1;
        for (int i = 0; i < 9; i++) tick("post_reset");

        for (int i = 0; i < 10; i++) begin
            fnd_serial = 32'($urandom_range(0, 1999999)) - 32'd900000;
            for (int k = 0; k < 7; k++) tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/segment_driver.md
# segment_driver

Six-digit multiplexed seven-segment display driver for the FPGA calculator. It converts a 32-bit signed display word into per-digit segment patterns. The word is either a decimal value or one of a set of message codes. The driver scans one digit per `fnd_clk` cycle. It sits after the calculator core and is clocked by the display clock from `clock_divider`.

## Interface
- No parameters.
- `fnd_clk`  in  1  display scan clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `fnd_serial`  in  32  signed display word (two's complement number or message code).
- `fnd_s`  out  6  digit select, active-low one-hot. Bit 0 is the rightmost digit, bit 5 the leftmost.
- `fnd_d`  out  8  segment pattern, active-high. Bits 0–6 are segments a–g; bit 7 is dp, always 0.

## Operation
- **Message codes.** Values `'h00XX_0000` with XX in {CC, EE, 10, 20, 30, 40, 50, A0} are messages. Text below is written leftmost digit (5) to rightmost (0); `_` is blank.
  - CC: all blank
  - EE: `Error_`
  - 10 (plus): `PLUS__`
  - 20 (minus): `nnInUS`
  - 30 (multiply): `nnULt_`
  - 40 (divide): `dIUIdE`
  - 50 (modulo): `nnOd__`
  - A0 (happy): `HAPPY_`
- **Glyphs.**
  - Letters/symbols: E=79, r=50, o=5C, P=73, L=38, U=3E, S=6D, n=54, I=06, t=78, d=5E, O=3F, H=76, A=77, Y=6E, minus=40, blank=00.
  - Digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- **Numeric range.** Any non-message value in −99999..999999 is shown as decimal.
- **Out of range.** Any other value is shown as `Error_`.
- **Number layout.**
  - Right-aligned.
  - Magnitude converted to BCD by shift-add-3 (double dabble, combinational over 20 bits).
  - Leading zeros blank.
  - Value 0 shows a single `0` in digit 0.
  - Negative values place a minus glyph in the digit immediately left of the most significant digit. Example: −12 shows `___-12`; −12345 shows `-12345`.
- **Pattern buffer.** Six 8-bit patterns, reloaded from `fnd_serial` every cycle.
- **Scan counter.**
  - Counts 0,1,2,3,4,5, then wraps to 0.
  - Each cycle `fnd_s` drives low only the bit equal to the counter.
  - `fnd_d` carries that digit's buffered pattern.

## Timing
- **Reset.** On an `fnd_clk` edge with `rst`=0:
  - scan counter = 0
  - buffer = all blank
  - `fnd_s` = 6'b111111
  - `fnd_d` = 8'h00
- **First scan after reset.** The first edge with `rst`=1 outputs digit 0 (`fnd_s`=6'b111110). At that point the buffer is still blank, so `fnd_d`=00.
- **Latency.** `fnd_serial` is sampled into the buffer at edge N. Outputs at edge N+1 use that buffer.
  - Worst case for a given digit to show new data: 7 edges.
  - Full refresh: 6 cycles.
- **Mid-frame changes.** A change in `fnd_serial` mid-frame is not held off. Digits already scanned keep showing the old value until their next turn; no tearing protection.
- **Reset mid-operation.** Takes effect on the next edge. Outputs go dark and the scan restarts at digit 0.
- **Outputs.** All outputs are registered; no combinational path from `fnd_serial` to outputs.

## Configuration
- Macro: `SEGMENT_ZERO_BLANK_EN`.
- **Defined:** leading-zero blanking and a floating minus sign, as above.
- **Undefined:**
  - All six digits are shown with leading zeros, e.g. 123 shows `000123`.
  - Negative values put the minus glyph in digit 5 and the zero-padded magnitude in digits 4–0; −12 shows `-00012`.
  - Message codes and the out-of-range error are unaffected.

## Test plan
- **Reset.** Hold `rst`=0 for 3 edges. Expect `fnd_s`=111111 and `fnd_d`=00 throughout. After release, expect `fnd_s` to cycle 111110, 111101, … 011111, then wrap back to 111110.
- **Positive number.** `fnd_serial`=123 (macro defined). Expect digits 0–2 = 4F, 5B, 06 and digits 3–5 = 00. With the macro undefined, digits 3–5 = 3F.
- **Negative number.** `fnd_serial`=−12345. Expect digit 5 = 40, then digits 4..0 = 06, 5B, 4F, 66, 6D. For −1, expect digit 1 = 40 and digit 0 = 06.
- **Zero.** `fnd_serial`=0. Expect digit 0 = 3F and all other digits = 00.
- **Messages.** Step through all message codes.
  - `'h00EE_0000` → 79, 50, 50, 5C, 50, 00 (digits 5→0).
  - `'h00A0_0000` → 76, 77, 73, 73, 6E, 00.
  - `'h00CC_0000` → all 00.
- **Out of range.** Values 1000000 and −100000 → `Error_` pattern. Asserting `rst`=0 mid-frame blanks outputs on the next edge.
